regfile_param: RTL and testbench

- Parametrised successor to the pipeline register file, sized by data width, address width and read-port count.
- Adds a write-to-read bypass and a per-register pending (scoreboard) bit for load-use hazard detection.
- Adds a runtime-selectable, registered debug tap in place of a hardwired observation register.
- Sits between the decode stage (reads, reserves) and the writeback stage (writes) of the pipelined processor.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 64 ++++++
 rtl/regfile_param.sv | 91 +++++++++
 tb/tb_regfile_param.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the parametrised pipeline register file.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_ADDR_WIDTH      = 5;
  localparam int DEF_NUM_READ        = 2;
  localparam int DEF_DEBUG_RESET_SEL = 27;
  localparam int ZERO_REG            = 0;

  // Low bit of a port's field inside a packed multi-port bus.
  function automatic int portLsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: tracks registers awaiting a load writeback and flags busy read sources.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = DEF_NUM_READ,
  parameter int BYPASS     = 1
) (
  input  logic                         clock,
  input  logic                         ctrl_reset,
  input  logic                         writeEnable_i,
  input  logic [ADDR_WIDTH-1:0]        writeReg_i,
  input  logic                         reserveEnable_i,
  input  logic [ADDR_WIDTH-1:0]        reserveReg_i,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] readReg_i,
  output logic [NUM_READ-1:0]          busyRead_o,
  output logic [ADDR_WIDTH:0]          pendingCount_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic [DEPTH-1:0] pending_q, pending_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wrEff, rsEff, incr, decr;

  assign wrEff = writeEnable_i && (writeReg_i != ZERO_IDX);
  assign rsEff = reserveEnable_i && (reserveReg_i != ZERO_IDX);

  // Reserve is applied after the write so a same-register pair leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    if (wrEff) pending_d[writeReg_i] = 1'b0;
    if (rsEff) pending_d[reserveReg_i] = 1'b1;
  end

  always_comb begin
    incr    = rsEff && !pending_q[reserveReg_i];
    decr    = wrEff && pending_q[writeReg_i] && !(rsEff && (reserveReg_i == writeReg_i));
    count_d = count_q + {{(CW-1){1'b0}}, incr} - {{(CW-1){1'b0}}, decr};
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pendingCount_o = count_q;

  for (genvar p = 0; p < NUM_READ; p++) begin : g_busy
    localparam int LSB = portLsb(p, ADDR_WIDTH);
    logic [ADDR_WIDTH-1:0] idx;
    assign idx = readReg_i[LSB +: ADDR_WIDTH];
    assign busyRead_o[p] = pending_q[idx] &&
                           !((BYPASS != 0) && writeEnable_i && (writeReg_i == idx));
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file with write-to-read bypass, load-use scoreboard and registered debug tap.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int NUM_READ        = DEF_NUM_READ,
  parameter int BYPASS          = 1,
  parameter int DEBUG_RESET_SEL = DEF_DEBUG_RESET_SEL
) (
  input  logic                           clock,
  input  logic                           ctrl_reset,
  input  logic                           ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]          data_writeReg,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
  output logic [NUM_READ-1:0]            busy_read,
  input  logic                           ctrl_reserveEnable,
  input  logic [ADDR_WIDTH-1:0]          ctrl_reserveReg,
  output logic [ADDR_WIDTH:0]            pending_count,
  input  logic                           ctrl_debugLoad,
  input  logic [ADDR_WIDTH-1:0]          ctrl_debugSel,
  output logic [DATA_WIDTH-1:0]          data_debug
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX  = ADDR_WIDTH'(ZERO_REG);
  localparam logic [ADDR_WIDTH-1:0] DEBUG_IDX = ADDR_WIDTH'(DEBUG_RESET_SEL);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [ADDR_WIDTH-1:0] debugSel_q, debugSel_d;
  logic [DATA_WIDTH-1:0] debugData_q, debugData_d;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (ctrl_writeEnable && (ctrl_writeReg != ZERO_IDX)) begin
      regs_q[ctrl_writeReg] <= data_writeReg;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_read
    localparam int ALSB = portLsb(p, ADDR_WIDTH);
    localparam int DLSB = portLsb(p, DATA_WIDTH);
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] rd;
    assign idx = ctrl_readReg[ALSB +: ADDR_WIDTH];
    always_comb begin
      rd = regs_q[idx];
      if ((BYPASS != 0) && ctrl_writeEnable && (ctrl_writeReg == idx)) rd = data_writeReg;
      if (idx == ZERO_IDX) rd = '0;
    end
    assign data_readReg[DLSB +: DATA_WIDTH] = rd;
  end

  // Tap samples the stored (pre-write) value under the current selection.
  always_comb begin
    debugSel_d  = ctrl_debugLoad ? ctrl_debugSel : debugSel_q;
    debugData_d = (debugSel_q == ZERO_IDX) ? '0 : regs_q[debugSel_q];
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      debugSel_q  <= DEBUG_IDX;
      debugData_q <= '0;
    end else begin
      debugSel_q  <= debugSel_d;
      debugData_q <= debugData_d;
    end
  end

  assign data_debug = debugData_q;

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ),
    .BYPASS     (BYPASS)
  ) u_scoreboard (
    .clock           (clock),
    .ctrl_reset      (ctrl_reset),
    .writeEnable_i   (ctrl_writeEnable),
    .writeReg_i      (ctrl_writeReg),
    .reserveEnable_i (ctrl_reserveEnable),
    .reserveReg_i    (ctrl_reserveReg),
    .readReg_i       (ctrl_readReg),
    .busyRead_o      (busy_read),
    .pendingCount_o  (pending_count)
  );

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed vector table plus randomized cycles against a reference model.
module tb_regfile_param;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        re;
    logic [4:0]  rreg;
    logic        dl;
    logic [4:0]  dsel;
    logic [4:0]  rd0;
    logic [4:0]  rd1;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] expRd0;
    logic [31:0] expRd0Nb;
    logic        expBusy0;
    logic [5:0]  expCount;
    logic [31:0] expDebug;
  } vec_t;

  logic        clock;
  logic        ctrl_reset, ctrl_writeEnable, ctrl_reserveEnable, ctrl_debugLoad;
  logic [4:0]  ctrl_writeReg, ctrl_reserveReg, ctrl_debugSel;
  logic [31:0] data_writeReg;
  logic [9:0]  ctrl_readReg;
  logic [63:0] rdByp, rdNb;
  logic [1:0]  busyByp, busyNb;
  logic [5:0]  cntByp, cntNb;
  logic [31:0] dbgByp, dbgNb;

  int checks = 0;
  int errors = 0;

  logic [31:0] mRegs [32];
  logic [31:0] mPend;
  logic [4:0]  mSel;
  logic [31:0] mDebug;

  regfile_param #(.BYPASS(1)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg), .ctrl_readReg(ctrl_readReg),
    .data_readReg(rdByp), .busy_read(busyByp), .ctrl_reserveEnable(ctrl_reserveEnable),
    .ctrl_reserveReg(ctrl_reserveReg), .pending_count(cntByp), .ctrl_debugLoad(ctrl_debugLoad),
    .ctrl_debugSel(ctrl_debugSel), .data_debug(dbgByp));

  regfile_param #(.BYPASS(0)) dutNb (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg), .ctrl_readReg(ctrl_readReg),
    .data_readReg(rdNb), .busy_read(busyNb), .ctrl_reserveEnable(ctrl_reserveEnable),
    .ctrl_reserveReg(ctrl_reserveReg), .pending_count(cntNb), .ctrl_debugLoad(ctrl_debugLoad),
    .ctrl_debugSel(ctrl_debugSel), .data_debug(dbgNb));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic stim_t st(input logic rst, input logic we, input logic [4:0] wreg,
                               input logic [31:0] wdata, input logic re, input logic [4:0] rreg,
                               input logic dl, input logic [4:0] dsel,
                               input logic [4:0] rd0, input logic [4:0] rd1);
    stim_t s;
    s.rst = rst; s.we = we; s.wreg = wreg; s.wdata = wdata; s.re = re; s.rreg = rreg;
    s.dl = dl; s.dsel = dsel; s.rd0 = rd0; s.rd1 = rd1;
    return s;
  endfunction

  // Reference read: register 0 is zero, a same-cycle write is forwarded only when bypass is on.
  function automatic logic [31:0] modelRead(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'd0;
    if (byp && ctrl_writeEnable && ctrl_writeReg == idx) return data_writeReg;
    return mRegs[idx];
  endfunction

  function automatic logic modelBusy(input logic [4:0] idx, input bit byp);
    return mPend[idx] && !(byp && ctrl_writeEnable && ctrl_writeReg == idx);
  endfunction

  task automatic modelEdge();
    if (ctrl_reset) begin
      for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
      mPend  = 32'd0;
      mSel   = 5'd27;
      mDebug = 32'd0;
    end else begin
      mDebug = (mSel == 5'd0) ? 32'd0 : mRegs[mSel];
      if (ctrl_debugLoad) mSel = ctrl_debugSel;
      if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
        mRegs[ctrl_writeReg] = data_writeReg;
        mPend[ctrl_writeReg] = 1'b0;
      end
      if (ctrl_reserveEnable && ctrl_reserveReg != 5'd0) mPend[ctrl_reserveReg] = 1'b1;
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    @(negedge clock);
    ctrl_reset         = s.rst;
    ctrl_writeEnable   = s.we;
    ctrl_writeReg      = s.wreg;
    data_writeReg      = s.wdata;
    ctrl_reserveEnable = s.re;
    ctrl_reserveReg    = s.rreg;
    ctrl_debugLoad     = s.dl;
    ctrl_debugSel      = s.dsel;
    ctrl_readReg       = {s.rd1, s.rd0};
  endtask

  // Combinational outputs are compared before the edge, registered ones just after it.
  task automatic checkOutput();
    logic [4:0] i0, i1;
    #1;
    i0 = ctrl_readReg[4:0];
    i1 = ctrl_readReg[9:5];
    check("read_byp", rdByp, {modelRead(i1, 1'b1), modelRead(i0, 1'b1)});
    check("read_nobyp", rdNb, {modelRead(i1, 1'b0), modelRead(i0, 1'b0)});
    check("busy_byp", {62'd0, busyByp}, {62'd0, modelBusy(i1, 1'b1), modelBusy(i0, 1'b1)});
    check("busy_nobyp", {62'd0, busyNb}, {62'd0, modelBusy(i1, 1'b0), modelBusy(i0, 1'b0)});
    @(posedge clock);
    modelEdge();
    #1;
    check("count_byp", {58'd0, cntByp}, 64'($countones(mPend)));
    check("count_nobyp", {58'd0, cntNb}, 64'($countones(mPend)));
    check("debug_byp", {32'd0, dbgByp}, {32'd0, mDebug});
    check("debug_nobyp", {32'd0, dbgNb}, {32'd0, mDebug});
  endtask

  vec_t tbl [21];

  initial begin
    stim_t s;
    for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
    mPend = 32'd0; mSel = 5'd27; mDebug = 32'd0;

    tbl[0]  = '{st(0,1,5,32'hDEADBEEF,0,0,0,0,5,5),  32'hDEADBEEF, 32'h0, 0, 6'd0, 32'h0};
    tbl[1]  = '{st(0,0,0,0,0,0,0,0,5,0),              32'hDEADBEEF, 32'hDEADBEEF, 0, 6'd0, 32'h0};
    tbl[2]  = '{st(0,1,0,32'h12345678,1,0,0,0,0,5),  32'h0, 32'h0, 0, 6'd0, 32'h0};
    tbl[3]  = '{st(0,0,0,0,0,0,0,0,0,0),              32'h0, 32'h0, 0, 6'd0, 32'h0};
    tbl[4]  = '{st(0,0,0,0,1,7,0,0,7,7),              32'h0, 32'h0, 0, 6'd1, 32'h0};
    tbl[5]  = '{st(0,0,0,0,0,0,0,0,7,0),              32'h0, 32'h0, 1, 6'd1, 32'h0};
    tbl[6]  = '{st(0,1,7,32'h55,0,0,0,0,7,7),         32'h55, 32'h0, 0, 6'd0, 32'h0};
    tbl[7]  = '{st(0,0,0,0,0,0,0,0,7,0),              32'h55, 32'h55, 0, 6'd0, 32'h0};
    tbl[8]  = '{st(0,0,0,0,1,9,0,0,9,0),              32'h0, 32'h0, 0, 6'd1, 32'h0};
    tbl[9]  = '{st(0,1,9,32'h99,1,9,0,0,9,9),         32'h99, 32'h0, 0, 6'd1, 32'h0};
    tbl[10] = '{st(0,0,0,0,0,0,0,0,9,0),              32'h99, 32'h99, 1, 6'd1, 32'h0};
    tbl[11] = '{st(0,0,0,0,1,4,0,0,4,9),              32'h0, 32'h0, 0, 6'd2, 32'h0};
    tbl[12] = '{st(0,1,4,32'h44,1,3,0,0,4,3),         32'h44, 32'h0, 0, 6'd2, 32'h0};
    tbl[13] = '{st(0,0,0,0,1,3,0,0,3,4),              32'h0, 32'h0, 1, 6'd2, 32'h0};
    tbl[14] = '{st(0,1,3,32'h11,0,0,0,0,3,3),         32'h11, 32'h0, 0, 6'd1, 32'h0};
    tbl[15] = '{st(0,1,27,32'hA5A5A5A5,0,0,0,0,27,0), 32'hA5A5A5A5, 32'h0, 0, 6'd1, 32'h0};
    tbl[16] = '{st(0,0,0,0,0,0,0,0,27,0),             32'hA5A5A5A5, 32'hA5A5A5A5, 0, 6'd1, 32'hA5A5A5A5};
    tbl[17] = '{st(0,0,0,0,0,0,1,3,3,0),              32'h11, 32'h11, 0, 6'd1, 32'hA5A5A5A5};
    tbl[18] = '{st(0,0,0,0,0,0,0,0,3,0),              32'h11, 32'h11, 0, 6'd1, 32'h11};
    tbl[19] = '{st(0,0,0,0,0,0,1,0,0,0),              32'h0, 32'h0, 0, 6'd1, 32'h11};
    tbl[20] = '{st(0,0,0,0,0,0,0,0,0,0),              32'h0, 32'h0, 0, 6'd1, 32'h0};

    ctrl_reset = 1'b1; ctrl_writeEnable = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
    ctrl_reserveEnable = 1'b0; ctrl_reserveReg = '0; ctrl_debugLoad = 1'b0;
    ctrl_debugSel = '0; ctrl_readReg = '0;

    applyStimulus(st(1,0,0,0,0,0,0,0,0,0));
    checkOutput();

    // Fill every register with ones and leave some pending, then reset.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(st(0,1,5'(i),32'hFFFFFFFF,(i % 3) == 0,5'(31 - i),0,0,5'(i),5'(31 - i)));
      checkOutput();
    end
    applyStimulus(st(1,0,0,0,0,0,1,5,9,10));
    checkOutput();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(st(0,0,0,0,0,0,0,0,5'(i),5'(31 - i)));
      #1;
      check("post_reset_read", rdByp, 64'd0);
      check("post_reset_busy", {62'd0, busyByp}, 64'd0);
      checkOutput();
    end

    foreach (tbl[v]) begin
      applyStimulus(tbl[v].s);
      #1;
      check($sformatf("vec%0d_rd0_byp", v), {32'd0, rdByp[31:0]}, {32'd0, tbl[v].expRd0});
      check($sformatf("vec%0d_rd0_nobyp", v), {32'd0, rdNb[31:0]}, {32'd0, tbl[v].expRd0Nb});
      check($sformatf("vec%0d_busy0", v), {63'd0, busyByp[0]}, {63'd0, tbl[v].expBusy0});
      checkOutput();
      check($sformatf("vec%0d_count", v), {58'd0, cntByp}, {58'd0, tbl[v].expCount});
      check($sformatf("vec%0d_debug", v), {32'd0, dbgByp}, {32'd0, tbl[v].expDebug});
    end

    for (int n = 0; n < 400; n++) begin
      s.rst   = ($urandom_range(0, 60) == 0);
      s.we    = $urandom_range(0, 1);
      s.wreg  = 5'($urandom_range(0, 7));
      s.wdata = $urandom;
      s.re    = ($urandom_range(0, 2) == 0);
      s.rreg  = ($urandom_range(0, 3) == 0) ? s.wreg : 5'($urandom_range(0, 31));
      s.dl    = ($urandom_range(0, 7) == 0);
      s.dsel  = 5'($urandom_range(0, 7));
      s.rd0   = ($urandom_range(0, 2) == 0) ? s.wreg : 5'($urandom_range(0, 7));
      s.rd1   = 5'($urandom_range(0, 31));
      applyStimulus(s);
      checkOutput();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
